calc_display_scan: RTL and testbench

- Reader side of the calc_pkg::num_t result bus. Takes the value produced by the calculator core and drives a time-multiplexed 8-digit seven-segment display, plus sign and error lamps.
- Segment encoding is calc_pkg::bcd2segments: bit 6 = segment a … bit 0 = segment g.
- Double-buffered so a new value never tears mid-frame. Sits between the calc core and the board display pins.

---
 rtl/calc_display_scan.sv | 172 +++++++++++++++++
 tb/tb_calc_display_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_display_scan.sv
// rtl/calc_display_scan.sv - double-buffered 8-digit multiplexed seven-segment display driver

package calc_pkg;

    localparam int NumDigits = 8;
    localparam int ExpW      = $clog2(NumDigits);

    typedef struct packed {
        logic                   error;
        logic                   sign;
        logic [ExpW-1:0]        exponent;
        logic [4*NumDigits-1:0] significand;
    } num_t;

    // Segment pattern for one BCD digit, bit 6 = a ... bit 0 = g
    function automatic logic [6:0] bcd2segments(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000001;
        endcase
        return seg;
    endfunction

endpackage

module calc_display_scan #(
    parameter int NumDigits = calc_pkg::NumDigits,
    parameter int ScanDiv   = 1000
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [$bits(calc_pkg::num_t)-1:0] num_i,
    input  logic                              load_i,
    output logic                              busy_o,
    output logic                              frame_o,
    output logic [NumDigits-1:0]              digit_en_o,
    output logic [6:0]                        segments_o,
    output logic                              dp_o,
    output logic                              sign_o,
    output logic                              error_o
);

    localparam int CntW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
    localparam int IdxW = (NumDigits > 1) ? $clog2(NumDigits) : 1;

    localparam logic [CntW-1:0] CntLast = CntW'(ScanDiv - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumDigits - 1);
    localparam logic [6:0]      SegE    = 7'b1001111;
    localparam logic [6:0]      SegDash = 7'b0000001;

    calc_pkg::num_t  num_in;
    calc_pkg::num_t  pending_q;
    calc_pkg::num_t  active_q;
    logic            pending_valid_q;
    logic [CntW-1:0] cnt_q;
    logic [IdxW-1:0] idx_q;
    logic            boundary;

    logic [3:0]           digits [NumDigits];
    logic [IdxW-1:0]      msd;
    logic [IdxW-1:0]      hi;
    logic [IdxW-1:0]      exp_idx;
    logic [3:0]           cur_bcd;
    logic [6:0]           seg_d;
    logic                 dp_d;
    logic [NumDigits-1:0] digit_en_d;
    logic                 sign_d;

    assign num_in   = calc_pkg::num_t'(num_i);
    assign boundary = (cnt_q == CntLast) && (idx_q == IdxLast);
    assign busy_o   = pending_valid_q;

    // Prescaler, digit index and the pending/active double buffer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            active_q        <= '0;
        end else begin
            if (cnt_q == CntLast) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (boundary) begin
                // A load landing on the boundary goes straight to the display
                if (load_i) begin
                    active_q        <= num_in;
                    pending_valid_q <= 1'b0;
                end else if (pending_valid_q) begin
                    active_q        <= pending_q;
                    pending_valid_q <= 1'b0;
                end
            end else if (load_i) begin
                pending_q       <= num_in;
                pending_valid_q <= 1'b1;
            end
        end
    end

    // Per-digit content: leading-zero blanking, dash for non-BCD, error 'E'
    always_comb begin
        msd = '0;
        for (int i = 0; i < NumDigits; i++) begin
            digits[i] = active_q.significand[4*i +: 4];
            if (digits[i] != 4'd0) begin
                msd = IdxW'(i);
            end
        end
        exp_idx = IdxW'(active_q.exponent);
        hi      = (exp_idx > msd) ? exp_idx : msd;
        cur_bcd = digits[idx_q];

        if (active_q.error) begin
            seg_d = (idx_q == '0) ? SegE : 7'b0;
            dp_d  = 1'b0;
        end else begin
            if (idx_q > hi) begin
                seg_d = 7'b0;
            end else if (cur_bcd > 4'd9) begin
                seg_d = SegDash;
            end else begin
                seg_d = calc_pkg::bcd2segments(cur_bcd);
            end
            dp_d = (idx_q == exp_idx);
        end

        digit_en_d = NumDigits'(1) << idx_q;
        // Dead cycle between digits suppresses ghosting on the shared segment lines
        if (cnt_q == '0) begin
            digit_en_d = '0;
            seg_d      = 7'b0;
            dp_d       = 1'b0;
        end

        sign_d = active_q.sign & ~active_q.error & (active_q.significand != '0);
    end

    // Registered display pins, one cycle behind the scan state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_o    <= 1'b0;
            digit_en_o <= '0;
            segments_o <= '0;
            dp_o       <= 1'b0;
            sign_o     <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            frame_o    <= boundary;
            digit_en_o <= digit_en_d;
            segments_o <= seg_d;
            dp_o       <= dp_d;
            sign_o     <= sign_d;
            error_o    <= active_q.error;
        end
    end

endmodule

// File: tb/tb_calc_display_scan.sv
// tb/tb_calc_display_scan.sv - directed self-checking bench for calc_display_scan

module tb_calc_display_scan;

    localparam int ND = 8;
    localparam int SD = 4;
    localparam int FR = ND * SD;

    logic                              clk = 1'b0;
    logic                              rst_n = 1'b0;
    logic [$bits(calc_pkg::num_t)-1:0] num_i = '0;
    logic                              load_i = 1'b0;
    logic                              busy_o;
    logic                              frame_o;
    logic [ND-1:0]                     digit_en_o;
    logic [6:0]                        segments_o;
    logic                              dp_o;
    logic                              sign_o;
    logic                              error_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [6:0] exp_seg [ND];
    int         exp_dp;

    calc_display_scan #(.NumDigits(ND), .ScanDiv(SD)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .num_i      (num_i),
        .load_i     (load_i),
        .busy_o     (busy_o),
        .frame_o    (frame_o),
        .digit_en_o (digit_en_o),
        .segments_o (segments_o),
        .dp_o       (dp_o),
        .sign_o     (sign_o),
        .error_o    (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [$bits(calc_pkg::num_t)-1:0] mk(input logic e, input logic s,
                                                             input logic [2:0] x, input logic [31:0] sig);
        return {e, s, x, sig};
    endfunction

    task automatic load(input logic [$bits(calc_pkg::num_t)-1:0] v);
        num_i  = v;
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < ND; i++) exp_seg[i] = 7'b0;
        exp_dp = -1;
    endtask

    // Observe one full frame; optionally load lv on the frame boundary cycle
    task automatic check_frame(input string tag, input logic es, input logic ee,
                               input bit do_load, input logic [$bits(calc_pkg::num_t)-1:0] lv);
        while (cyc % FR != 1) tick();
        chk({tag, ".sign"}, 32'(sign_o), 32'(es));
        chk({tag, ".error"}, 32'(error_o), 32'(ee));
        for (int n = 0; n < FR; n++) begin
            int k;
            int c;
            int d;
            logic [31:0] een;
            logic [31:0] esg;
            logic [31:0] edp;
            k = cyc - 1;
            c = k % SD;
            d = (k / SD) % ND;
            een = (c == 0) ? 32'd0 : (32'd1 << d);
            esg = (c == 0) ? 32'd0 : 32'(exp_seg[d]);
            edp = (c != 0 && d == exp_dp) ? 32'd1 : 32'd0;
            chk({tag, ".digit_en"}, 32'(digit_en_o), een);
            chk({tag, ".segments"}, 32'(segments_o), esg);
            chk({tag, ".dp"}, 32'(dp_o), edp);
            chk({tag, ".frame"}, 32'(frame_o), (cyc % FR == 0) ? 32'd1 : 32'd0);
            if (do_load && (cyc % FR == FR - 1)) begin
                num_i  = lv;
                load_i = 1'b1;
            end
            tick();
            load_i = 1'b0;
        end
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst.digit_en", 32'(digit_en_o), 0);
        chk("rst.segments", 32'(segments_o), 0);
        chk("rst.busy", 32'(busy_o), 0);
        chk("rst.frame", 32'(frame_o), 0);
        chk("rst.lamps", {30'd0, sign_o, error_o}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;

        // 1: zero value shows '0' with dp on digit 0
        clear_exp();
        exp_seg[0] = 7'b1111110;
        exp_dp     = 0;
        check_frame("t1a", 1'b0, 1'b0, 1'b0, '0);
        check_frame("t1b", 1'b0, 1'b0, 1'b0, '0);

        // 2: 1234 with exponent 2, busy until boundary
        tick();
        load(mk(1'b0, 1'b0, 3'd2, 32'h0000_1234));
        chk("t2.busy_set", 32'(busy_o), 1);
        while (cyc % FR != FR - 1) tick();
        chk("t2.busy_hold", 32'(busy_o), 1);
        tick();
        chk("t2.busy_clr", 32'(busy_o), 0);
        clear_exp();
        exp_seg[0] = 7'b0110011;
        exp_seg[1] = 7'b1111001;
        exp_seg[2] = 7'b1101101;
        exp_seg[3] = 7'b0110000;
        exp_dp     = 2;
        check_frame("t2", 1'b0, 1'b0, 1'b0, '0);

        // 3: blanking stops at the exponent
        load(mk(1'b0, 1'b0, 3'd3, 32'h0000_0005));
        clear_exp();
        exp_seg[0] = 7'b1011011;
        exp_seg[1] = 7'b1111110;
        exp_seg[2] = 7'b1111110;
        exp_seg[3] = 7'b1111110;
        exp_dp     = 3;
        check_frame("t3", 1'b0, 1'b0, 1'b0, '0);

        // 4: error overrides digits, dp and sign
        load(mk(1'b1, 1'b1, 3'd1, 32'h0000_0099));
        clear_exp();
        exp_seg[0] = 7'b1001111;
        check_frame("t4", 1'b0, 1'b1, 1'b0, '0);

        // 5: A then B in one frame (B wins, digit 0 is a dash), C loaded on the boundary
        load(mk(1'b0, 1'b0, 3'd0, 32'h0000_0008));
        while (cyc % FR != 10) tick();
        load(mk(1'b0, 1'b0, 3'd0, 32'h0000_002A));
        clear_exp();
        exp_seg[0] = 7'b0000001;
        exp_seg[1] = 7'b1101101;
        exp_dp     = 0;
        check_frame("t5b", 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 3'd1, 32'h0000_0006));
        chk("t5.busy_after_c", 32'(busy_o), 0);
        clear_exp();
        exp_seg[0] = 7'b1011111;
        exp_seg[1] = 7'b1111110;
        exp_dp     = 1;
        check_frame("t5c", 1'b0, 1'b0, 1'b0, '0);

        // 6: negative zero has no minus, negative seven does
        load(mk(1'b0, 1'b1, 3'd0, 32'h0000_0000));
        clear_exp();
        exp_seg[0] = 7'b1111110;
        exp_dp     = 0;
        check_frame("t6z", 1'b0, 1'b0, 1'b0, '0);
        load(mk(1'b0, 1'b1, 3'd0, 32'h0000_0007));
        clear_exp();
        exp_seg[0] = 7'b1110000;
        exp_dp     = 0;
        check_frame("t6n", 1'b1, 1'b0, 1'b0, '0);

        // Reset mid-frame with a pending value
        load(mk(1'b0, 1'b0, 3'd1, 32'h0000_0099));
        chk("t6.busy_pend", 32'(busy_o), 1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("t6r.digit_en", 32'(digit_en_o), 0);
        chk("t6r.segments", 32'(segments_o), 0);
        chk("t6r.busy", 32'(busy_o), 0);
        chk("t6r.lamps", {29'd0, sign_o, error_o, dp_o}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        clear_exp();
        exp_seg[0] = 7'b1111110;
        exp_dp     = 0;
        check_frame("t6r_a", 1'b0, 1'b0, 1'b0, '0);
        check_frame("t6r_b", 1'b0, 1'b0, 1'b0, '0);
        chk("t6r.busy_end", 32'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
